// File: rtl/cnn_pkg.sv
// Shared CNN datapath types.
//   DATA_WIDTH : default pixel width (two's-complement signed fixed point)
//   pixel_t    : signed pixel of DATA_WIDTH bits
//   smax       : signed maximum of two pixels
package cnn_pkg;

  localparam int DATA_WIDTH = 24;

  typedef logic signed [DATA_WIDTH-1:0] pixel_t;

  function automatic pixel_t smax(input pixel_t a, input pixel_t b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pool_max2.sv
// Combinational two-input signed maximum.
//   a, b : signed operands (WIDTH bits)
//   y    : the larger of a and b; on a tie, b is returned
module pool_max2 #(
  parameter int WIDTH = cnn_pkg::DATA_WIDTH
) (
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  output logic signed [WIDTH-1:0] y
);

  // Both operands are declared signed, so this is a full-width two's-complement compare.
  assign y = (a > b) ? a : b;

endmodule

// File: rtl/maxpool2x2_stream.sv
// 2x2 stride-2 max pooling on a raster-scan pixel stream, one-row line buffer,
// no backpressure (every valid_in pixel is accepted).
//   clk       : rising-edge clock
//   rst       : asynchronous active-low reset
//   data_in   : signed input pixel, qualified by valid_in
//   data_out  : signed pooled pixel, qualified by valid_out
//   valid_out : one-cycle pulse per pooled pixel, one cycle after its odd-row/odd-col input
//   last_out  : high with valid_out on the final pooled pixel of a frame
// Build option: define MAXPOOL_RELU_EN to clamp negative pooled results to zero.
module maxpool2x2_stream #(
  parameter int DATA_WIDTH = cnn_pkg::DATA_WIDTH,
  parameter int IMG_WIDTH  = 10,
  parameter int IMG_HEIGHT = 10
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic signed [DATA_WIDTH-1:0] data_in,
  input  logic                         valid_in,
  output logic signed [DATA_WIDTH-1:0] data_out,
  output logic                         valid_out,
  output logic                         last_out
);

  import cnn_pkg::*;

  localparam int CW       = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int RW       = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam int LB_DEPTH = IMG_WIDTH / 2;
  localparam int LB_IW    = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;

  localparam logic [CW-1:0] COL_LAST      = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST      = RW'(IMG_HEIGHT - 1);
  // Last column/row that belongs to a complete 2x2 window; a trailing odd
  // column or row lies beyond these and only advances the counters.
  localparam logic [CW-1:0] GRID_COL_LAST = CW'(2 * (IMG_WIDTH / 2) - 1);
  localparam logic [RW-1:0] GRID_ROW_LAST = RW'(2 * (IMG_HEIGHT / 2) - 1);

  logic [CW-1:0]                 col;
  logic [RW-1:0]                 row;
  logic signed [DATA_WIDTH-1:0]  hold;
  logic signed [DATA_WIDTH-1:0]  linebuf [LB_DEPTH];

  logic                          in_grid;
  logic                          last_pix;
  logic [LB_IW-1:0]              lb_idx;
  logic signed [DATA_WIDTH-1:0]  lb_rd;
  logic signed [DATA_WIDTH-1:0]  hold_max;
  logic signed [DATA_WIDTH-1:0]  pair_max;
  logic signed [DATA_WIDTH-1:0]  pool_val;

  assign in_grid  = (col <= GRID_COL_LAST) && (row <= GRID_ROW_LAST);
  assign last_pix = (col == GRID_COL_LAST) && (row == GRID_ROW_LAST);
  assign lb_rd    = linebuf[lb_idx];

  // Odd row, even col: fold the incoming pixel into the upper-row pair max.
  pool_max2 #(.WIDTH(DATA_WIDTH)) u_hold_max (
    .a (data_in),
    .b (lb_rd),
    .y (hold_max)
  );

  // Odd col: combine with the even-col value in hold. On an even row this is
  // the upper-row pair stored to the line buffer; on an odd row it is the
  // complete 2x2 window maximum.
  pool_max2 #(.WIDTH(DATA_WIDTH)) u_out_max (
    .a (hold),
    .b (data_in),
    .y (pair_max)
  );

  // NOTE: every signal driven in always_comb gets a value on every path
  // (defaults first), otherwise synthesis infers a latch.
  always_comb begin
    lb_idx   = '0;
    pool_val = pair_max;
    // Out-of-grid columns would index past the buffer; park the read on entry 0.
    if (in_grid) lb_idx = LB_IW'(col >> 1);
`ifdef MAXPOOL_RELU_EN
    pool_val = pair_max[DATA_WIDTH-1] ? '0 : pair_max;
`else
    pool_val = pair_max;
`endif
  end

  // NOTE: clocked state uses non-blocking (<=) so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col       <= '0;
      row       <= '0;
      hold      <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
      last_out  <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      last_out  <= 1'b0;
      if (valid_in) begin
        if (col == COL_LAST) begin
          col <= '0;
          row <= (row == ROW_LAST) ? '0 : row + RW'(1);
        end else begin
          col <= col + CW'(1);
        end

        if (in_grid) begin
          case ({row[0], col[0]})
            2'b00: hold <= data_in;
            2'b10: hold <= hold_max;
            2'b11: begin
              data_out  <= pool_val;
              valid_out <= 1'b1;
              last_out  <= last_pix;
            end
            default: ;
          endcase
        end
      end
    end
  end

  // NOTE: the line buffer is deliberately not reset; each entry is written on
  // an even row before the following odd row reads it, so stale contents never
  // reach the output and the array can map to plain storage.
  always_ff @(posedge clk) begin
    if (valid_in && in_grid && !row[0] && col[0]) begin
      linebuf[lb_idx] <= pair_max;
    end
  end

endmodule

// File: tb/tb_maxpool2x2_stream.sv
// Self-checking bench for maxpool2x2_stream: table of frame-level cases on a
// 10x10 instance, plus hand sequences for mid-frame reset and a 5x5 instance.
module tb_maxpool2x2_stream;

  localparam int DW = 24;

  logic                 clk = 1'b0;
  logic                 rst;
  logic signed [DW-1:0] data_a, data_b, out_a, out_b;
  logic                 valid_a, valid_b, vout_a, vout_b, last_a, last_b;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  maxpool2x2_stream #(.DATA_WIDTH(DW), .IMG_WIDTH(10), .IMG_HEIGHT(10)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .data_in   (data_a),
    .valid_in  (valid_a),
    .data_out  (out_a),
    .valid_out (vout_a),
    .last_out  (last_a)
  );

  maxpool2x2_stream #(.DATA_WIDTH(DW), .IMG_WIDTH(5), .IMG_HEIGHT(5)) u_odd (
    .clk       (clk),
    .rst       (rst),
    .data_in   (data_b),
    .valid_in  (valid_b),
    .data_out  (out_b),
    .valid_out (vout_b),
    .last_out  (last_b)
  );

  typedef struct {
    logic signed [DW-1:0] value;
    bit                   last;
    int                   cyc;
  } out_t;

  out_t got_a[$], got_b[$], exp_a[$], exp_b[$];

  // Capture every output pulse away from the active edge.
  always @(negedge clk) begin
    if (vout_a) got_a.push_back('{out_a, last_a, cyc});
    if (vout_b) got_b.push_back('{out_b, last_b, cyc});
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic longint pix(input int r, input int c, input int w,
                                 input int offset, input bit neg);
    if (neg) return -longint'(r * w + c + 1);
    return longint'(r * w + c + offset);
  endfunction

  // Reference 2x2 window maximum whose bottom-right pixel is (r, c).
  function automatic longint pool_ref(input int r, input int c, input int w,
                                      input int offset, input bit neg);
    longint m;
    longint v;
    m = pix(r - 1, c - 1, w, offset, neg);
    v = pix(r - 1, c, w, offset, neg); if (v > m) m = v;
    v = pix(r, c - 1, w, offset, neg); if (v > m) m = v;
    v = pix(r, c, w, offset, neg);     if (v > m) m = v;
`ifdef MAXPOOL_RELU_EN
    if (m < 0) m = 0;
`endif
    return m;
  endfunction

  // Drive npix raster pixels; gap>1 inserts gap-1 idle cycles after each pixel.
  task automatic drive(input bit sel, input int w, input int h, input int offset,
                       input bit neg, input int gap, input int npix);
    for (int p = 0; p < npix; p++) begin
      int   r;
      int   c;
      out_t e;
      r = (p / w) % h;
      c = p % w;
      @(posedge clk); #1;
      if (sel) begin
        data_b  = DW'(pix(r, c, w, offset, neg));
        valid_b = 1'b1;
      end else begin
        data_a  = DW'(pix(r, c, w, offset, neg));
        valid_a = 1'b1;
      end
      if ((r % 2 == 1) && (c % 2 == 1) && (r < 2 * (h / 2)) && (c < 2 * (w / 2))) begin
        e.value = DW'(pool_ref(r, c, w, offset, neg));
        e.last  = (r == 2 * (h / 2) - 1) && (c == 2 * (w / 2) - 1);
        e.cyc   = cyc + 1;
        if (sel) exp_b.push_back(e);
        else     exp_a.push_back(e);
      end
      for (int g = 1; g < gap; g++) begin
        @(posedge clk); #1;
        valid_a = 1'b0;
        valid_b = 1'b0;
        data_a  = 24'h5a5a5a;
        data_b  = 24'h5a5a5a;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      valid_a = 1'b0;
      valid_b = 1'b0;
    end
  endtask

  task automatic compare(input bit sel, input string name);
    out_t g[$];
    out_t e[$];
    int   n;
    if (sel) begin g = got_b; e = exp_b; end
    else     begin g = got_a; e = exp_a; end
    check({name, " count"}, g.size(), e.size());
    n = (g.size() < e.size()) ? g.size() : e.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s[%0d] value", name, i), g[i].value, e[i].value);
      check($sformatf("%s[%0d] last", name, i), g[i].last, e[i].last);
      check($sformatf("%s[%0d] cycle", name, i), g[i].cyc, e[i].cyc);
    end
    if (sel) begin got_b.delete(); exp_b.delete(); end
    else     begin got_a.delete(); exp_a.delete(); end
  endtask

  typedef struct {
    string name;
    bit    neg;
    int    gap;
    int    frames;
    int    n_out;
    int    first_val;
    int    last_val;
  } case_t;

`ifdef MAXPOOL_RELU_EN
  localparam int NEG_FIRST = 0;
  localparam int NEG_LAST  = 0;
`else
  localparam int NEG_FIRST = -1;
  localparam int NEG_LAST  = -89;
`endif

  case_t cases[4];
  int    odd_vals[4];
  int    nlast;

  initial begin
    cases[0] = '{"ramp",     1'b0, 1, 1, 25, 11, 99};
    cases[1] = '{"negative", 1'b1, 1, 1, 25, NEG_FIRST, NEG_LAST};
    cases[2] = '{"gapped",   1'b0, 3, 1, 25, 11, 99};
    cases[3] = '{"b2b",      1'b0, 1, 2, 50, 11, 1099};
    odd_vals = '{6, 8, 16, 18};

    rst     = 1'b0;
    valid_a = 1'b0;
    valid_b = 1'b0;
    data_a  = '0;
    data_b  = '0;

    repeat (3) @(posedge clk);
    #1;
    check("reset data_out", out_a, 0);
    check("reset valid_out", vout_a, 0);
    check("reset last_out", last_a, 0);
    check("reset odd data_out", out_b, 0);
    rst = 1'b1;
    idle(2);

    for (int k = 0; k < 4; k++) begin
      for (int f = 0; f < cases[k].frames; f++)
        drive(1'b0, 10, 10, f * 1000, cases[k].neg, cases[k].gap, 100);
      idle(3);
      check({cases[k].name, " outputs"}, got_a.size(), cases[k].n_out);
      if (got_a.size() > 0) begin
        check({cases[k].name, " first"}, got_a[0].value, cases[k].first_val);
        check({cases[k].name, " final"}, got_a[got_a.size()-1].value, cases[k].last_val);
        check({cases[k].name, " final last_out"}, got_a[got_a.size()-1].last, 1);
      end
      nlast = 0;
      foreach (got_a[i]) if (got_a[i].last) nlast++;
      check({cases[k].name, " last pulses"}, nlast, cases[k].frames);
      compare(1'b0, cases[k].name);
    end

    // Mid-frame reset: 37 pixels yield rows 1 (5 outputs) and 3 cols 1,3,5.
    drive(1'b0, 10, 10, 0, 1'b0, 1, 37);
    idle(2);
    check("midframe partial outputs", got_a.size(), 8);
    compare(1'b0, "midframe partial");
    rst = 1'b0;
    #1;
    check("midframe reset data_out", out_a, 0);
    check("midframe reset valid_out", vout_a, 0);
    repeat (3) @(posedge clk);
    #1;
    check("outputs during reset", got_a.size(), 0);
    rst = 1'b1;
    drive(1'b0, 10, 10, 0, 1'b0, 1, 100);
    idle(3);
    check("post-reset outputs", got_a.size(), 25);
    if (got_a.size() == 25) begin
      check("post-reset first", got_a[0].value, 11);
      check("post-reset final", got_a[24].value, 99);
    end
    compare(1'b0, "post-reset");

    // 5x5 instance: trailing column 4 and row 4 are ignored.
    drive(1'b1, 5, 5, 0, 1'b0, 1, 25);
    idle(3);
    check("odd outputs", got_b.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < got_b.size()) begin
        check($sformatf("odd value %0d", i), got_b[i].value, odd_vals[i]);
        check($sformatf("odd last %0d", i), got_b[i].last, (i == 3) ? 1 : 0);
      end
    end
    compare(1'b1, "odd");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
